// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared types and helpers for the systolic feed scheduler.
//   state_t      : scheduler FSM state (idle, feeding, draining, done pulse)
//   Def*         : default operand widths and matrix dimensions
//   max_u        : larger of two unsigned values
//   clog2_min1   : $clog2 that never returns 0 (for counter/index widths)
//   feed_steps   : number of skewed feed steps F = N + M + L - 2
//   addr_width   : config address width covering the larger operand buffer
// ----------------------------------------------------------------------------
package systolic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_t;

    localparam int unsigned DefWidthLeft = 4;
    localparam int unsigned DefWidthUp   = 4;
    localparam int unsigned DefM         = 3;
    localparam int unsigned DefN         = 4;
    localparam int unsigned DefL         = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int unsigned feed_steps(input int unsigned m, input int unsigned n,
                                               input int unsigned l);
        return n + m + l - 2;
    endfunction

    function automatic int unsigned addr_width(input int unsigned m, input int unsigned n,
                                               input int unsigned l);
        return clog2_min1(max_u(m * n, n * l));
    endfunction

endpackage

// File: rtl/systolic_operand_buf.sv
// ----------------------------------------------------------------------------
// systolic_operand_buf
// Operand register array with one write port and a combinational, diagonally
// skewed read of every lane for a given feed step.
//   LaneMajor = 1 : storage is lane-major (A: index lane*Inner + k)
//   LaneMajor = 0 : storage is inner-major (B: index k*Lanes + lane)
// Lane l at step s reads element k = s - l; lanes with k outside 0..Inner-1
// read zero.
// Ports:
//   clk      in   clock, rising edge (array has no reset)
//   i_we     in   write strobe (already qualified by the scheduler)
//   i_addr   in   row-major element index; out-of-range writes are dropped
//   i_wdata  in   element value
//   i_step   in   feed step to read
//   o_lanes  out  lane l at bits [l*Width +: Width]
// ----------------------------------------------------------------------------
module systolic_operand_buf #(
    parameter int unsigned Lanes     = 3,
    parameter int unsigned Inner     = 4,
    parameter int unsigned Width     = 4,
    parameter int unsigned AddrW     = 4,
    parameter int unsigned StepW     = 3,
    parameter bit          LaneMajor = 1'b1
) (
    input  logic                   clk,
    input  logic                   i_we,
    input  logic [AddrW-1:0]       i_addr,
    input  logic [Width-1:0]       i_wdata,
    input  logic [StepW-1:0]       i_step,
    output logic [Lanes*Width-1:0] o_lanes
);

    localparam int unsigned Depth = Lanes * Inner;
    localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] r_mem [Depth];
    logic             w_in_range;
    logic             w_we;

    assign w_in_range = (32'(i_addr) < Depth);
    assign w_we       = i_we && w_in_range;

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[i_addr[IdxW-1:0]] <= i_wdata;
        end
    end

    // A write landing on the same edge as the read must be visible, so the
    // write data is forwarded onto any lane reading that element.
    always_comb begin
        int k;
        int idx;
        o_lanes = '0;
        k       = 0;
        idx     = 0;
        for (int l = 0; l < int'(Lanes); l++) begin
            k = int'(i_step) - l;
            if (k >= 0 && k < int'(Inner)) begin
                idx = LaneMajor ? (l * int'(Inner) + k) : (k * int'(Lanes) + l);
                if (w_we && (32'(i_addr) == 32'(idx))) begin
                    o_lanes[l*Width +: Width] = i_wdata;
                end else begin
                    o_lanes[l*Width +: Width] = r_mem[idx[IdxW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_feed_scheduler.sv
// ----------------------------------------------------------------------------
// systolic_feed_scheduler
// Buffers operand matrices A (MxN) and B (NxL) written over a config port and,
// on start, streams them into a systolic array with per-lane diagonal skew,
// waits out the drain latency, then pulses done.
// Optional feature: define FEED_CYCLE_CNT_EN to add the cycle_count output.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous reset, active-high
//   cfg_we       in   operand write strobe (ignored while busy)
//   cfg_sel      in   0 = A buffer, 1 = B buffer
//   cfg_addr     in   row-major element index (A: i*N+k, B: k*L+j)
//   cfg_wdata    in   element value, LSBs used
//   start        in   start request, only accepted in idle
//   busy         out  high while feeding and draining
//   done         out  one-cycle completion pulse
//   valid_left   out  left bus carries a feed step
//   valid_up     out  up bus carries a feed step
//   left         out  lane i at bits [i*WIDTH_left +: WIDTH_left]
//   up           out  lane j at bits [j*WIDTH_up +: WIDTH_up]
//   cycle_count  out  (FEED_CYCLE_CNT_EN only) busy cycles of the last run
// ----------------------------------------------------------------------------
module systolic_feed_scheduler
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH_left = DefWidthLeft,
    parameter int unsigned WIDTH_up   = DefWidthUp,
    parameter int unsigned Mritx_M    = DefM,
    parameter int unsigned Mritx_N    = DefN,
    parameter int unsigned Mritx_L    = DefL,
    parameter int unsigned DRAIN_CYC  = Mritx_M + Mritx_L - 1,
    parameter int unsigned ADDR_W     = addr_width(Mritx_M, Mritx_N, Mritx_L)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_we,
    input  logic                                   cfg_sel,
    input  logic [ADDR_W-1:0]                      cfg_addr,
    input  logic [max_u(WIDTH_left, WIDTH_up)-1:0] cfg_wdata,
    input  logic                                   start,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   valid_left,
    output logic                                   valid_up,
    output logic [Mritx_M*WIDTH_left-1:0]          left,
    output logic [Mritx_L*WIDTH_up-1:0]            up
`ifdef FEED_CYCLE_CNT_EN
    ,
    output logic [15:0]                            cycle_count
`endif
);

    localparam int unsigned F      = feed_steps(Mritx_M, Mritx_N, Mritx_L);
    localparam int unsigned StepW  = clog2_min1(F);
    localparam int unsigned DrainW = clog2_min1(DRAIN_CYC);
    localparam int unsigned LeftW  = Mritx_M * WIDTH_left;
    localparam int unsigned UpW    = Mritx_L * WIDTH_up;

    state_t            r_state;
    logic [StepW-1:0]  r_step;
    logic [DrainW-1:0] r_drain;
    logic              r_busy;
    logic              r_done;
    logic              r_valid;
    logic [LeftW-1:0]  r_left;
    logic [UpW-1:0]    r_up;

    state_t            w_state_nxt;
    logic [StepW-1:0]  w_step_nxt;
    logic [DrainW-1:0] w_drain_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_valid_nxt;
    logic [LeftW-1:0]  w_left_nxt;
    logic [UpW-1:0]    w_up_nxt;

    logic              w_we_a;
    logic              w_we_b;
    logic [StepW-1:0]  w_rd_step;
    logic [LeftW-1:0]  w_left_lanes;
    logic [UpW-1:0]    w_up_lanes;

    // Busy is low in idle and in the done cycle, so writes are accepted there.
    assign w_we_a = cfg_we && !r_busy && !cfg_sel;
    assign w_we_b = cfg_we && !r_busy && cfg_sel;

    // Outputs are registered, so the buffers are read one step ahead: step 0
    // while idle (for a start), step+1 while feeding.
    assign w_rd_step = (r_state == StFeed) ? (r_step + StepW'(1)) : '0;

    systolic_operand_buf #(
        .Lanes    (Mritx_M),
        .Inner    (Mritx_N),
        .Width    (WIDTH_left),
        .AddrW    (ADDR_W),
        .StepW    (StepW),
        .LaneMajor(1'b1)
    ) u_buf_a (
        .clk    (clk),
        .i_we   (w_we_a),
        .i_addr (cfg_addr),
        .i_wdata(cfg_wdata[WIDTH_left-1:0]),
        .i_step (w_rd_step),
        .o_lanes(w_left_lanes)
    );

    systolic_operand_buf #(
        .Lanes    (Mritx_L),
        .Inner    (Mritx_N),
        .Width    (WIDTH_up),
        .AddrW    (ADDR_W),
        .StepW    (StepW),
        .LaneMajor(1'b0)
    ) u_buf_b (
        .clk    (clk),
        .i_we   (w_we_b),
        .i_addr (cfg_addr),
        .i_wdata(cfg_wdata[WIDTH_up-1:0]),
        .i_step (w_rd_step),
        .o_lanes(w_up_lanes)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        w_drain_nxt = r_drain;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_valid_nxt = 1'b0;
        w_left_nxt  = '0;
        w_up_nxt    = '0;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt = StFeed;
                    w_step_nxt  = '0;
                    w_drain_nxt = '0;
                    w_busy_nxt  = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_left_nxt  = w_left_lanes;
                    w_up_nxt    = w_up_lanes;
                end
            end
            StFeed: begin
                if (r_step == StepW'(F - 1)) begin
                    // Step counter holds at its last value on exit.
                    if (DRAIN_CYC == 0) begin
                        w_state_nxt = StDone;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = StDrain;
                        w_drain_nxt = '0;
                        w_busy_nxt  = 1'b1;
                    end
                end else begin
                    w_step_nxt  = r_step + StepW'(1);
                    w_busy_nxt  = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_left_nxt  = w_left_lanes;
                    w_up_nxt    = w_up_lanes;
                end
            end
            StDrain: begin
                if (r_drain == DrainW'(DRAIN_CYC - 1)) begin
                    w_state_nxt = StDone;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_nxt = r_drain + DrainW'(1);
                    w_busy_nxt  = 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_step  <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_left  <= '0;
            r_up    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_drain <= w_drain_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_valid <= w_valid_nxt;
            r_left  <= w_left_nxt;
            r_up    <= w_up_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign valid_left = r_valid;
    assign valid_up   = r_valid;
    assign left       = r_left;
    assign up         = r_up;

`ifdef FEED_CYCLE_CNT_EN
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (r_state == StIdle && start) begin
            r_cycle_cnt <= '0;
        end else if (r_busy && r_cycle_cnt != 16'hFFFF) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign cycle_count = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
module tb_systolic_feed_scheduler;

    localparam int M = 3;
    localparam int N = 4;
    localparam int L = 3;
    localparam int W = 4;
    localparam int F = N + M + L - 2;
    localparam int D = M + L - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic        cfg_sel;
    logic [3:0]  cfg_addr;
    logic [3:0]  cfg_wdata;
    logic        start;
    logic        busy;
    logic        done;
    logic        valid_left;
    logic        valid_up;
    logic [11:0] left;
    logic [11:0] up;
`ifdef FEED_CYCLE_CNT_EN
    logic [15:0] cycle_count;
`endif

    int total = 0;
    int bad   = 0;
    int ma[M*N];
    int mb[N*L];

    always #5 clk = ~clk;

    systolic_feed_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .valid_left(valid_left),
        .valid_up  (valid_up),
        .left      (left),
        .up        (up)
`ifdef FEED_CYCLE_CNT_EN
        ,
        .cycle_count(cycle_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Matrix-product feed order: left lane i carries A[i][s-i], up lane j B[s-j][j].
    function automatic logic [11:0] exp_left(input int s);
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < M; i++) begin
            if (s - i >= 0 && s - i < N) v[i*W +: W] = 4'(ma[i*N + (s - i)]);
        end
        return v;
    endfunction

    function automatic logic [11:0] exp_up(input int s);
        logic [11:0] v;
        v = '0;
        for (int j = 0; j < L; j++) begin
            if (s - j >= 0 && s - j < N) v[j*W +: W] = 4'(mb[(s - j)*L + j]);
        end
        return v;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/done"}, done, 0);
        chk({tag, "/valid_left"}, valid_left, 0);
        chk({tag, "/valid_up"}, valid_up, 0);
        chk({tag, "/left"}, left, 0);
        chk({tag, "/up"}, up, 0);
    endtask

    // Idle write; the model takes it only when the index is a real element.
    task automatic wr(input bit sel, input int addr, input int data);
        cfg_we    = 1'b1;
        cfg_sel   = sel;
        cfg_addr  = 4'(addr);
        cfg_wdata = 4'(data);
        tick();
        cfg_we = 1'b0;
        if (addr < M*N) begin
            if (sel) mb[addr] = data & 15;
            else ma[addr] = data & 15;
        end
    endtask

    task automatic load_seq();
        for (int a = 0; a < M*N; a++) wr(1'b0, a, a + 1);
        for (int a = 0; a < N*L; a++) wr(1'b1, a, a + 1);
    endtask

    // One full run from an idle cycle with exact cycle timing.
    task automatic run(input string tag, input bit hold, input bit busy_wr);
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        if (!hold) start = 1'b0;
        for (int s = 0; s < F; s++) begin
            chk($sformatf("%s/s%0d/valid_left", tag, s), valid_left, 1);
            chk($sformatf("%s/s%0d/valid_up", tag, s), valid_up, 1);
            chk($sformatf("%s/s%0d/busy", tag, s), busy, 1);
            chk($sformatf("%s/s%0d/done", tag, s), done, 0);
            chk($sformatf("%s/s%0d/left", tag, s), left, exp_left(s));
            chk($sformatf("%s/s%0d/up", tag, s), up, exp_up(s));
            if (busy_wr && s == 2) begin
                cfg_we    = 1'b1;
                cfg_sel   = 1'b0;
                cfg_addr  = 4'd0;
                cfg_wdata = 4'd9;
            end
            tick();
            cfg_we = 1'b0;
        end
        for (int d = 0; d < D; d++) begin
            chk($sformatf("%s/d%0d/busy", tag, d), busy, 1);
            chk($sformatf("%s/d%0d/valid", tag, d), {valid_left, valid_up}, 0);
            chk($sformatf("%s/d%0d/done", tag, d), done, 0);
            chk($sformatf("%s/d%0d/bus", tag, d), {left, up}, 0);
            tick();
        end
        chk({tag, "/done_pulse"}, done, 1);
        chk({tag, "/done_busy"}, busy, 0);
        chk({tag, "/done_valid"}, {valid_left, valid_up}, 0);
`ifdef FEED_CYCLE_CNT_EN
        chk({tag, "/cycle_count"}, cycle_count, F + D);
`endif
        tick();
        chk({tag, "/done_drop"}, done, 0);
        chk({tag, "/idle_busy"}, busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_sel   = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        start     = 1'b0;
        tick();
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        // Directed run with A = B = 1..12.
        load_seq();
        run("dir", 1'b0, 1'b0);

        // Write during busy is dropped; next run still sees A[0][0] = 1.
        run("busy_wr", 1'b0, 1'b1);
        run("after_busy_wr", 1'b0, 1'b0);

        // Write together with start: the run uses the new value.
        cfg_we    = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = 4'd0;
        cfg_wdata = 4'd9;
        ma[0]     = 9;
        run("same_cycle_wr", 1'b0, 1'b0);

        // Start held high: back-to-back runs, out-of-range writes dropped.
        load_seq();
        start = 1'b1;
        run("hold1", 1'b1, 1'b0);
        cfg_we    = 1'b1;
        cfg_sel   = 1'b0;
        cfg_addr  = 4'd15;
        cfg_wdata = 4'd6;
        run("hold2", 1'b1, 1'b0);
        cfg_we    = 1'b1;
        cfg_sel   = 1'b1;
        cfg_addr  = 4'd12;
        cfg_wdata = 4'd7;
        run("hold3", 1'b1, 1'b0);
        start = 1'b0;
        tick();
        check_idle("hold_end");

        // Reset in the middle of feeding (step 3).
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_mid/step3_left", left, exp_left(3));
        #2 rst = 1'b1;
        #1 check_idle("rst_mid_async");
        tick();
        check_idle("rst_mid_held");
        rst = 1'b0;
        tick();
        check_idle("rst_mid_release");
        load_seq();
        run("rst_rerun", 1'b0, 1'b0);

        // Randomized operands and addresses.
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < M*N; a++) wr(1'b0, a, int'($urandom_range(0, 15)));
            for (int a = 0; a < N*L; a++) wr(1'b1, a, int'($urandom_range(0, 15)));
            for (int x = 0; x < 4; x++) begin
                wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)));
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                tick();
                check_idle($sformatf("rnd%0d_gap", r));
            end
            run($sformatf("rnd%0d", r), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
